// File: rtl/axi_portal_master_if.sv
// Host command/data/response methods plus MAXIGP0 AXI3-subset channels for axi_portal_master.
interface axi_portal_master_if;
  // host command method
  logic        cmd_ena;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [11:0] cmd_id;
  logic        cmd_rdy;
  // host write-data method
  logic        wdata_ena;
  logic [31:0] wdata_v;
  logic        wdata_rdy;
  // AXI read address
  logic        axi_ar_ena;
  logic [31:0] axi_ar_addr;
  logic [11:0] axi_ar_id;
  logic [3:0]  axi_ar_len;
  logic        axi_ar_rdy;
  // AXI write address
  logic        axi_aw_ena;
  logic [31:0] axi_aw_addr;
  logic [11:0] axi_aw_id;
  logic [3:0]  axi_aw_len;
  logic        axi_aw_rdy;
  // AXI write data
  logic        axi_w_ena;
  logic [31:0] axi_w_data;
  logic [11:0] axi_w_id;
  logic        axi_w_last;
  logic        axi_w_rdy;
  // AXI read data
  logic        axi_r_ena;
  logic [31:0] axi_r_data;
  logic [11:0] axi_r_id;
  logic        axi_r_last;
  logic [1:0]  axi_r_resp;
  logic        axi_r_rdy;
  // AXI write response
  logic        axi_b_ena;
  logic [11:0] axi_b_id;
  logic [1:0]  axi_b_resp;
  logic        axi_b_rdy;
  // host read-beat method
  logic        rdata_ena;
  logic [31:0] rdata_v;
  logic        rdata_last;
  logic        rdata_err;
  logic        rdata_rdy;
  // host write-completion method
  logic        done_ena;
  logic [11:0] done_id;
  logic [1:0]  done_resp;
  logic        done_rdy;

  modport master (
    input  cmd_ena, cmd_write, cmd_addr, cmd_len, cmd_id,
    output cmd_rdy,
    input  wdata_ena, wdata_v,
    output wdata_rdy,
    output axi_ar_ena, axi_ar_addr, axi_ar_id, axi_ar_len,
    input  axi_ar_rdy,
    output axi_aw_ena, axi_aw_addr, axi_aw_id, axi_aw_len,
    input  axi_aw_rdy,
    output axi_w_ena, axi_w_data, axi_w_id, axi_w_last,
    input  axi_w_rdy,
    input  axi_r_ena, axi_r_data, axi_r_id, axi_r_last, axi_r_resp,
    output axi_r_rdy,
    input  axi_b_ena, axi_b_id, axi_b_resp,
    output axi_b_rdy,
    output rdata_ena, rdata_v, rdata_last, rdata_err,
    input  rdata_rdy,
    output done_ena, done_id, done_resp,
    input  done_rdy
  );

  modport slave (
    output cmd_ena, cmd_write, cmd_addr, cmd_len, cmd_id,
    input  cmd_rdy,
    output wdata_ena, wdata_v,
    input  wdata_rdy,
    input  axi_ar_ena, axi_ar_addr, axi_ar_id, axi_ar_len,
    output axi_ar_rdy,
    input  axi_aw_ena, axi_aw_addr, axi_aw_id, axi_aw_len,
    output axi_aw_rdy,
    input  axi_w_ena, axi_w_data, axi_w_id, axi_w_last,
    output axi_w_rdy,
    output axi_r_ena, axi_r_data, axi_r_id, axi_r_last, axi_r_resp,
    input  axi_r_rdy,
    output axi_b_ena, axi_b_id, axi_b_resp,
    input  axi_b_rdy,
    input  rdata_ena, rdata_v, rdata_last, rdata_err,
    output rdata_rdy,
    input  done_ena, done_id, done_resp,
    output done_rdy
  );
endinterface

// File: rtl/axi_portal_master.sv
// AXI3-subset initiator for the portal link: 1-deep command register, AR/AW issue,
// W burst sequencing, combinational R/B forwarding, outstanding-burst throttling.
// Optional macro AXI_MASTER_ERRCNT_EN adds a saturating error-response counter (err_count).
module axi_portal_master #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  axi_portal_master_if.master        bus,
  output logic                       busy
`ifdef AXI_MASTER_ERRCNT_EN
  , output logic [15:0]              err_count
`endif
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 12;
  localparam int unsigned LEN_W  = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {W_IDLE, W_DATA} wstate_e;

  wstate_e           r_state, w_state_nxt;
  logic              r_cmd_valid;
  logic              r_cmd_write;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [LEN_W-1:0]  r_cmd_len;
  logic [ID_W-1:0]   r_cmd_id;
  logic [CNT_W-1:0]  r_rd_out, r_wr_out;
  logic [LEN_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic [ID_W-1:0]   r_w_id, w_w_id_nxt;

  logic w_cmd_xfer, w_ar_xfer, w_aw_ena, w_w_ena, w_wdata_rdy, w_w_last;
  logic w_r_xfer, w_r_last_xfer, w_b_xfer;
  logic w_unused_rid;

  // command acceptance checks the counter of the incoming command's direction
  assign bus.cmd_rdy = ~r_cmd_valid &
                       (bus.cmd_write ? (r_wr_out < MAX_CNT) : (r_rd_out < MAX_CNT));
  assign w_cmd_xfer  = bus.cmd_ena & bus.cmd_rdy;

  // read address issues straight from the command register
  assign bus.axi_ar_ena  = r_cmd_valid & ~r_cmd_write & bus.axi_ar_rdy;
  assign bus.axi_ar_addr = r_cmd_addr;
  assign bus.axi_ar_id   = r_cmd_id;
  assign bus.axi_ar_len  = r_cmd_len;
  assign w_ar_xfer       = bus.axi_ar_ena;

  assign bus.axi_aw_ena  = w_aw_ena;
  assign bus.axi_aw_addr = r_cmd_addr;
  assign bus.axi_aw_id   = r_cmd_id;
  assign bus.axi_aw_len  = r_cmd_len;

  assign bus.axi_w_ena   = w_w_ena;
  assign bus.axi_w_data  = bus.wdata_v;
  assign bus.axi_w_id    = r_w_id;
  assign bus.axi_w_last  = w_w_last;
  assign bus.wdata_rdy   = w_wdata_rdy;

  // R and B are forwarded to the host without buffering
  assign bus.rdata_ena   = bus.axi_r_ena & bus.rdata_rdy;
  assign bus.axi_r_rdy   = bus.rdata_rdy;
  assign bus.rdata_v     = bus.axi_r_data;
  assign bus.rdata_last  = bus.axi_r_last;
  assign bus.rdata_err   = (bus.axi_r_resp != 2'b00);
  assign w_r_xfer        = bus.rdata_ena;
  assign w_r_last_xfer   = w_r_xfer & bus.axi_r_last;

  assign bus.done_ena    = bus.axi_b_ena & bus.done_rdy;
  assign bus.axi_b_rdy   = bus.done_rdy;
  assign bus.done_id     = bus.axi_b_id;
  assign bus.done_resp   = bus.axi_b_resp;
  assign w_b_xfer        = bus.done_ena;

  assign w_unused_rid    = ^bus.axi_r_id;

  assign busy = r_cmd_valid | (r_state == W_DATA) | (r_rd_out != '0) | (r_wr_out != '0);

  // write FSM state, beat counter and burst id registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= W_IDLE;
      r_beat_cnt <= '0;
      r_w_id     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_w_id     <= w_w_id_nxt;
    end
  end

  // write FSM next state and AW/W handshake outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_w_id_nxt     = r_w_id;
    w_aw_ena       = 1'b0;
    w_w_ena        = 1'b0;
    w_w_last       = 1'b0;
    w_wdata_rdy    = 1'b0;
    case (r_state)
      W_IDLE: begin
        w_aw_ena = r_cmd_valid & r_cmd_write & bus.axi_aw_rdy;
        if (w_aw_ena) begin
          w_state_nxt    = W_DATA;
          w_beat_cnt_nxt = r_cmd_len;
          w_w_id_nxt     = r_cmd_id;
        end
      end
      W_DATA: begin
        w_wdata_rdy = bus.axi_w_rdy;
        w_w_ena     = bus.wdata_ena & bus.axi_w_rdy;
        w_w_last    = (r_beat_cnt == '0);
        if (w_w_ena) begin
          if (w_w_last) w_state_nxt = W_IDLE;
          else          w_beat_cnt_nxt = r_beat_cnt - LEN_W'(1);
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // one-deep command register: filled on push, freed by the AR or AW transfer
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_len   <= '0;
      r_cmd_id    <= '0;
    end else if (w_cmd_xfer) begin
      r_cmd_valid <= 1'b1;
      r_cmd_write <= bus.cmd_write;
      r_cmd_addr  <= bus.cmd_addr;
      r_cmd_len   <= bus.cmd_len;
      r_cmd_id    <= bus.cmd_id;
    end else if (w_ar_xfer | w_aw_ena) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // outstanding burst counters; decrements saturate at zero
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rd_out <= '0;
      r_wr_out <= '0;
    end else begin
      case ({w_ar_xfer, w_r_last_xfer})
        2'b10:   r_rd_out <= r_rd_out + CNT_W'(1);
        2'b01:   if (r_rd_out != '0) r_rd_out <= r_rd_out - CNT_W'(1);
        default: ;
      endcase
      case ({w_aw_ena, w_b_xfer})
        2'b10:   r_wr_out <= r_wr_out + CNT_W'(1);
        2'b01:   if (r_wr_out != '0) r_wr_out <= r_wr_out - CNT_W'(1);
        default: ;
      endcase
    end
  end

`ifdef AXI_MASTER_ERRCNT_EN
  logic [1:0]  w_err_inc;
  logic [16:0] w_err_sum;
  assign w_err_inc = 2'(w_r_xfer & (bus.axi_r_resp != 2'b00)) +
                     2'(w_b_xfer & (bus.axi_b_resp != 2'b00));
  assign w_err_sum = {1'b0, err_count} + 17'(w_err_inc);

  // saturating count of error responses seen on R and B
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)               err_count <= '0;
    else if (w_err_sum[16])  err_count <= 16'hFFFF;
    else                     err_count <= w_err_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_axi_portal_master.sv
// Randomized + directed bench for axi_portal_master against a transaction-level reference model.
module tb_axi_portal_master;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic nrst;
  logic busy;
`ifdef AXI_MASTER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  axi_portal_master_if bus();

  axi_portal_master #(.MAX_OUTSTANDING(4), .CNT_W(4)) dut (
    .CLK(clk),
    .nRST(nrst),
    .bus(bus),
    .busy(busy)
`ifdef AXI_MASTER_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: held command, outstanding burst counts, active W burst
  logic        m_held_v, m_held_w;
  logic [31:0] m_held_addr;
  logic [3:0]  m_held_len;
  logic [11:0] m_held_id;
  int          m_rd_out, m_wr_out, m_beats_left, m_err;
  logic        m_in_burst;
  logic [11:0] m_burst_id;
  // responder bookkeeping: read bursts awaiting R beats, write ids awaiting B
  logic [3:0]  rq[$];
  logic [11:0] bq[$];
  int          r_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_busy();
    return m_held_v || m_in_burst || (m_rd_out != 0) || (m_wr_out != 0);
  endfunction

  task automatic model_reset();
    m_held_v = 0; m_held_w = 0; m_held_addr = '0; m_held_len = '0; m_held_id = '0;
    m_rd_out = 0; m_wr_out = 0; m_beats_left = 0; m_err = 0;
    m_in_burst = 0; m_burst_id = '0;
    rq.delete(); bq.delete(); r_idx = 0;
  endtask

  task automatic idle_inputs();
    bus.cmd_ena = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_id = '0;
    bus.wdata_ena = 0; bus.wdata_v = '0;
    bus.axi_ar_rdy = 1; bus.axi_aw_rdy = 1; bus.axi_w_rdy = 1;
    bus.axi_r_ena = 0; bus.axi_r_data = '0; bus.axi_r_id = '0; bus.axi_r_last = 0; bus.axi_r_resp = '0;
    bus.axi_b_ena = 0; bus.axi_b_id = '0; bus.axi_b_resp = '0;
    bus.rdata_rdy = 1; bus.done_rdy = 1;
  endtask

  // called just after a falling edge with inputs driven: checks outputs, advances model over the next rising edge
  task automatic step();
    logic e_cmd_rdy, e_ar, e_aw, e_w, e_wrdy, e_rd, e_dn, cmd_x, r_last_x;
    #1;
    if (!nrst) model_reset();
    e_cmd_rdy = !m_held_v && (bus.cmd_write ? (m_wr_out < MAX_OUT) : (m_rd_out < MAX_OUT));
    e_ar  = m_held_v && !m_held_w && bus.axi_ar_rdy;
    e_aw  = m_held_v && m_held_w && !m_in_burst && bus.axi_aw_rdy;
    e_wrdy = m_in_burst && bus.axi_w_rdy;
    e_w   = e_wrdy && bus.wdata_ena;
    e_rd  = bus.axi_r_ena && bus.rdata_rdy;
    e_dn  = bus.axi_b_ena && bus.done_rdy;
    check("cmd_rdy", 64'(bus.cmd_rdy), 64'(e_cmd_rdy));
    check("ar_ena", 64'(bus.axi_ar_ena), 64'(e_ar));
    check("aw_ena", 64'(bus.axi_aw_ena), 64'(e_aw));
    check("w_ena", 64'(bus.axi_w_ena), 64'(e_w));
    check("wdata_rdy", 64'(bus.wdata_rdy), 64'(e_wrdy));
    check("rdata_ena", 64'(bus.rdata_ena), 64'(e_rd));
    check("done_ena", 64'(bus.done_ena), 64'(e_dn));
    check("r_rdy", 64'(bus.axi_r_rdy), 64'(bus.rdata_rdy));
    check("b_rdy", 64'(bus.axi_b_rdy), 64'(bus.done_rdy));
    check("busy", 64'(busy), 64'(m_busy()));
    if (e_ar) check("ar_fields", 64'({bus.axi_ar_addr, bus.axi_ar_id, bus.axi_ar_len}),
                    64'({m_held_addr, m_held_id, m_held_len}));
    if (e_aw) check("aw_fields", 64'({bus.axi_aw_addr, bus.axi_aw_id, bus.axi_aw_len}),
                    64'({m_held_addr, m_held_id, m_held_len}));
    if (e_w) check("w_fields", 64'({bus.axi_w_data, bus.axi_w_id, bus.axi_w_last}),
                   64'({bus.wdata_v, m_burst_id, (m_beats_left == 1)}));
    if (e_rd) check("rdata_fields", 64'({bus.rdata_v, bus.rdata_last, bus.rdata_err}),
                    64'({bus.axi_r_data, bus.axi_r_last, (bus.axi_r_resp != 2'b00)}));
    if (e_dn) check("done_fields", 64'({bus.done_id, bus.done_resp}),
                    64'({bus.axi_b_id, bus.axi_b_resp}));
`ifdef AXI_MASTER_ERRCNT_EN
    check("err_count", 64'(err_count), 64'(m_err));
`endif
    if (nrst) begin
      cmd_x    = bus.cmd_ena && e_cmd_rdy;
      r_last_x = e_rd && bus.axi_r_last;
      if (e_ar && !r_last_x) m_rd_out++;
      else if (!e_ar && r_last_x && m_rd_out > 0) m_rd_out--;
      if (e_aw && !e_dn) m_wr_out++;
      else if (!e_aw && e_dn && m_wr_out > 0) m_wr_out--;
      if (e_ar) begin m_held_v = 0; rq.push_back(m_held_len); end
      if (e_aw) begin
        m_held_v = 0; m_in_burst = 1;
        m_beats_left = int'(m_held_len) + 1; m_burst_id = m_held_id;
      end
      if (e_w) begin
        m_beats_left--;
        if (m_beats_left == 0) begin m_in_burst = 0; bq.push_back(m_burst_id); end
      end
      if (cmd_x) begin
        m_held_v = 1; m_held_w = bus.cmd_write; m_held_addr = bus.cmd_addr;
        m_held_len = bus.cmd_len; m_held_id = bus.cmd_id;
      end
      if (e_rd && bus.axi_r_resp != 2'b00) m_err++;
      if (e_dn && bus.axi_b_resp != 2'b00) m_err++;
      if (m_err > 65535) m_err = 65535;
      if (e_rd && rq.size() > 0) begin
        if (bus.axi_r_last) begin void'(rq.pop_front()); r_idx = 0; end
        else r_idx++;
      end
      if (e_dn && bq.size() > 0) void'(bq.pop_front());
    end
    @(negedge clk);
  endtask

  // responder drives R/B only for bursts it owes; probabilities set by caller
  task automatic drive_responses(input int pct);
    bus.axi_r_data = $urandom;
    bus.axi_r_id   = 12'($urandom);
    bus.axi_r_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    bus.axi_b_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    if (rq.size() > 0 && $urandom_range(1, 100) <= pct) begin
      bus.axi_r_ena  = 1;
      bus.axi_r_last = (r_idx == int'(rq[0]));
    end else begin
      bus.axi_r_ena  = 0;
      bus.axi_r_last = 0;
    end
    if (bq.size() > 0 && $urandom_range(1, 100) <= pct) begin
      bus.axi_b_ena = 1; bus.axi_b_id = bq[0];
    end else begin
      bus.axi_b_ena = 0; bus.axi_b_id = 12'($urandom);
    end
  endtask

  task automatic drive_random();
    bus.cmd_ena    = ($urandom_range(0, 2) == 0);
    bus.cmd_write  = 1'($urandom_range(0, 1));
    bus.cmd_addr   = $urandom;
    bus.cmd_len    = 4'($urandom_range(0, 3));
    bus.cmd_id     = 12'($urandom);
    bus.wdata_ena  = ($urandom_range(0, 3) != 0);
    bus.wdata_v    = $urandom;
    bus.axi_ar_rdy = ($urandom_range(0, 3) != 0);
    bus.axi_aw_rdy = ($urandom_range(0, 3) != 0);
    bus.axi_w_rdy  = ($urandom_range(0, 3) != 0);
    bus.rdata_rdy  = ($urandom_range(0, 3) != 0);
    bus.done_rdy   = ($urandom_range(0, 3) != 0);
    drive_responses(40);
  endtask

  task automatic set_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len, input logic [11:0] id);
    bus.cmd_ena = 1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_len = len; bus.cmd_id = id;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    nrst = 0;
    @(negedge clk);
    step();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cmd_rdy", 64'(bus.cmd_rdy), 64'(1));
    step();
    nrst = 1;
    step();

    // single read burst, four beats back
    set_cmd(0, 32'h40, 4'd3, 12'd5);
    step();
    bus.cmd_ena = 0;
    #1 check("t1_ar", 64'({bus.axi_ar_ena, bus.axi_ar_addr, bus.axi_ar_len, bus.axi_ar_id}),
                      64'({1'b1, 32'h40, 4'd3, 12'd5}));
    step();
    for (int i = 0; i < 4; i++) begin
      bus.axi_r_ena = 1; bus.axi_r_data = 32'h100 + 32'(i); bus.axi_r_last = (i == 3); bus.axi_r_resp = 0;
      step();
    end
    bus.axi_r_ena = 0; bus.axi_r_last = 0;
    #1 check("t1_idle", 64'(busy), 64'(0));
    step();

    // two-beat write burst and its completion
    set_cmd(1, 32'h80, 4'd1, 12'd7);
    step();
    bus.cmd_ena = 0;
    #1 check("t2_aw", 64'({bus.axi_aw_ena, bus.axi_aw_id, bus.axi_aw_len, bus.wdata_rdy}),
                      64'({1'b1, 12'd7, 4'd1, 1'b0}));
    step();
    bus.wdata_ena = 1; bus.wdata_v = 32'hA;
    #1 check("t2_w0", 64'({bus.axi_w_ena, bus.axi_w_data, bus.axi_w_last, bus.axi_w_id}),
                      64'({1'b1, 32'hA, 1'b0, 12'd7}));
    step();
    bus.wdata_v = 32'hB;
    #1 check("t2_w1", 64'({bus.axi_w_ena, bus.axi_w_data, bus.axi_w_last, bus.axi_w_id}),
                      64'({1'b1, 32'hB, 1'b1, 12'd7}));
    step();
    bus.wdata_ena = 0;
    bus.axi_b_ena = 1; bus.axi_b_id = 12'd7; bus.axi_b_resp = 2'd0;
    #1 check("t2_done", 64'({bus.done_ena, bus.done_id, bus.done_resp}), 64'({1'b1, 12'd7, 2'd0}));
    step();
    bus.axi_b_ena = 0;
    step();

    // read throttling at MAX_OUTSTANDING while writes remain accepted
    for (int i = 0; i < 4; i++) begin
      set_cmd(0, 32'h1000 + 32'(i * 16), 4'd0, 12'(i));
      step();
      bus.cmd_ena = 0;
      step();
    end
    bus.cmd_write = 0;
    #1 check("t3_rd_full", 64'(bus.cmd_rdy), 64'(0));
    bus.cmd_write = 1;
    #1 check("t3_wr_ok", 64'(bus.cmd_rdy), 64'(1));
    step();
    bus.cmd_write = 0;
    bus.axi_r_ena = 1; bus.axi_r_last = 1; bus.axi_r_resp = 0;
    step();
    bus.axi_r_ena = 0;
    #1 check("t3_rd_again", 64'(bus.cmd_rdy), 64'(1));
    step();
    for (int i = 0; i < 3; i++) begin
      bus.axi_r_ena = 1; bus.axi_r_last = 1;
      step();
    end
    bus.axi_r_ena = 0;
    step();

    // second write held until the first W burst finishes
    set_cmd(1, 32'h200, 4'd3, 12'd1);
    step();
    bus.cmd_ena = 0;
    step();
    set_cmd(1, 32'h300, 4'd0, 12'd2);
    step();
    bus.cmd_ena = 0;
    for (int i = 0; i < 4; i++) begin
      bus.wdata_ena = 1; bus.wdata_v = 32'hC0 + 32'(i);
      #1 check("t4_aw_blocked", 64'(bus.axi_aw_ena), 64'(0));
      step();
    end
    bus.wdata_ena = 0;
    #1 check("t4_aw_after", 64'({bus.axi_aw_ena, bus.axi_aw_id}), 64'({1'b1, 12'd2}));
    step();
    bus.wdata_ena = 1; bus.wdata_v = 32'hD0;
    step();
    bus.wdata_ena = 0;
    bus.axi_b_ena = 1; bus.axi_b_id = 12'd1;
    step();
    bus.axi_b_id = 12'd2;
    step();
    bus.axi_b_ena = 0;
    step();

    // asynchronous reset in the middle of a four-beat W burst
    set_cmd(1, 32'h400, 4'd3, 12'd9);
    step();
    bus.cmd_ena = 0;
    step();
    bus.wdata_ena = 1; bus.wdata_v = 32'hE0;
    step();
    bus.wdata_v = 32'hE1;
    #2 nrst = 0;
    #1 check("t6_enas", 64'({bus.axi_ar_ena, bus.axi_aw_ena, bus.axi_w_ena, bus.wdata_rdy}), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    @(negedge clk);
    bus.wdata_ena = 0;
    step();
    nrst = 1;
    #1 check("t6_cmd_rdy", 64'(bus.cmd_rdy), 64'(1));
    step();
    bus.axi_r_ena = 1; bus.axi_r_last = 1; bus.axi_r_resp = 0;
    bus.axi_b_ena = 1; bus.axi_b_id = 12'd3; bus.axi_b_resp = 0;
    step();
    bus.axi_r_ena = 0; bus.axi_b_ena = 0;
    #1 check("t6_no_underflow", 64'({busy, bus.cmd_rdy}), 64'({1'b0, 1'b1}));
    step();

    // simultaneous error responses on R and B
    bus.axi_r_ena = 1; bus.axi_r_last = 1; bus.axi_r_resp = 2'd2; bus.axi_r_data = 32'h55;
    bus.axi_b_ena = 1; bus.axi_b_id = 12'd4; bus.axi_b_resp = 2'd2;
    #1 check("t5_rerr", 64'(bus.rdata_err), 64'(1));
    check("t5_bresp", 64'(bus.done_resp), 64'(2));
    step();
    bus.axi_r_ena = 0; bus.axi_b_ena = 0; bus.axi_r_resp = 0; bus.axi_b_resp = 0;
`ifdef AXI_MASTER_ERRCNT_EN
    #1 check("t5_errcnt", 64'(err_count), 64'(2));
`endif
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      step();
    end

    // drain everything still in flight, bounded
    idle_inputs();
    for (int c = 0; c < 400 && m_busy(); c++) begin
      bus.wdata_ena = 1; bus.wdata_v = $urandom;
      drive_responses(100);
      step();
    end
    idle_inputs();
    #1 check("drain_busy", 64'(busy), 64'(0));
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
